// File: rtl/firebird7_in_gate1_tessent_ijtag_pkg.sv
// Shared types and constants for the gate1 functional-side IJTAG CSU sequencer.
package firebird7_in_gate1_tessent_ijtag_pkg;

  // Sequencer states; one CSU sequence walks IDLE -> [CAPTURE] -> SHIFT -> UPDATE -> RESP.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    RESP    = 3'd4
  } csu_state_t;

  // Cycles a capture-enabled request spends beyond its shift length before rsp_valid rises.
  localparam int CSU_OVERHEAD = 3;

  // A request is only executed when it shifts at least one bit and fits the data vectors.
  function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_ijtag_csu_sequencer_if.sv
// Request/response bus between a BIST controller and the IJTAG CSU sequencer.
//
// Handshake: both channels are valid/ready. A transfer happens on the rising
// clock edge where valid and ready are both 1. Once valid is raised the source
// holds valid and its payload stable until that edge; ready may toggle freely
// and never depends combinationally on valid.
interface firebird7_in_gate1_tessent_ijtag_csu_sequencer_if #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               req_valid;
  logic               req_ready;
  logic [LEN_W-1:0]   req_len;
  logic               req_capture;
  logic [MAX_LEN-1:0] req_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;

  // Requester side (BIST controller or bench).
  modport master (
    output req_valid, req_len, req_capture, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_len, req_capture, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_ijtag_shifter.sv
// Scan datapath: shift-out register, scan-in capture vector and bit counter.
// load starts a new request, shift advances one scan bit, done flags the last bit.
module firebird7_in_gate1_tessent_ijtag_shifter #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] data,
  input  logic               so,
  output logic               done,
  output logic               next_bit,
  output logic [MAX_LEN-1:0] captured
);
  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;

  // Next datapath values: load restarts, shift consumes bit 0 and stores so at cnt.
  always_comb begin
    shift_d = shift_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (load) begin
      shift_d = data;
      cap_d   = '0;
      cnt_d   = '0;
      len_d   = len;
    end else if (shift) begin
      shift_d = {1'b0, shift_q[MAX_LEN-1:1]};
      for (int i = 0; i < MAX_LEN; i++) begin
        if (cnt_q == LEN_W'(i)) cap_d[i] = so;
      end
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  // Datapath registers; the counter cannot wrap because len never exceeds MAX_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign done     = (cnt_q == len_q - LEN_W'(1));
  // The bit that will sit at the head of the shift register next cycle, so si can be registered.
  assign next_bit = shift_d[0];
  assign captured = cap_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_ijtag_csu_sequencer.sv
// Functional-side IJTAG master: runs one capture-shift-update sequence per
// request into the gate1 SIB network and returns the scanned-out bits.
module firebird7_in_gate1_tessent_ijtag_csu_sequencer
  import firebird7_in_gate1_tessent_ijtag_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic       ijtag_tck,
  input  logic       ijtag_reset,
  firebird7_in_gate1_tessent_ijtag_csu_sequencer_if.slave csu,
  output logic       ijtag_sel,
  output logic       ijtag_ce,
  output logic       ijtag_se,
  output logic       ijtag_ue,
  output logic       ijtag_si,
  input  logic       ijtag_so,
  output csu_state_t state_dbg
);
  csu_state_t state_q, state_d;
  logic       load, shift, done, next_bit, len_legal;
  logic       req_ready_q, rsp_valid_q, rsp_err_q;
  logic       sel_q, ce_q, se_q, ue_q, si_q;

  assign len_legal = len_ok(32'(csu.req_len), MAX_LEN);

  // Next-state and datapath control; a bad length skips straight to RESP with no network activity.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (csu.req_valid && req_ready_q) begin
          load = 1'b1;
          if (!len_legal)           state_d = RESP;
          else if (csu.req_capture) state_d = CAPTURE;
          else                      state_d = SHIFT;
        end
      end
      CAPTURE: state_d = SHIFT;
      SHIFT: begin
        shift = 1'b1;
        if (done) state_d = UPDATE;
      end
      UPDATE: state_d = RESP;
      RESP: begin
        if (rsp_valid_q && csu.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; network controls are decoded from the next state so
  // they line up with the state they belong to, rsp_valid follows one cycle into RESP.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      sel_q       <= 1'b0;
      ce_q        <= 1'b0;
      se_q        <= 1'b0;
      ue_q        <= 1'b0;
      si_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_q == RESP) && (state_d == RESP);
      if (load)                                    rsp_err_q <= !len_legal;
      else if (state_q == RESP && state_d == IDLE) rsp_err_q <= 1'b0;
      sel_q       <= (state_d == CAPTURE) || (state_d == SHIFT) || (state_d == UPDATE);
      ce_q        <= (state_d == CAPTURE);
      se_q        <= (state_d == SHIFT);
      ue_q        <= (state_d == UPDATE);
      si_q        <= (state_d == SHIFT) ? next_bit : 1'b0;
    end
  end

  firebird7_in_gate1_tessent_ijtag_shifter #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_shifter (
    .clk     (ijtag_tck),
    .rst_n   (ijtag_reset),
    .load    (load),
    .shift   (shift),
    .len     (csu.req_len),
    .data    (csu.req_data),
    .so      (ijtag_so),
    .done    (done),
    .next_bit(next_bit),
    .captured(csu.rsp_data)
  );

  assign csu.req_ready = req_ready_q;
  assign csu.rsp_valid = rsp_valid_q;
  assign csu.rsp_err   = rsp_err_q;
  assign ijtag_sel     = sel_q;
  assign ijtag_ce      = ce_q;
  assign ijtag_se      = se_q;
  assign ijtag_ue      = ue_q;
  assign ijtag_si      = si_q;
  assign state_dbg     = state_q;

endmodule
